// File: rtl/cnu_lut_stage_pipe_pkg.sv
// Shared types, default configuration and the per-edge route function for cnu_lut_stage_pipe.
package cnu_lut_stage_pipe_pkg;

   localparam int unsigned DEF_CNU_NUM         = 2;
   localparam int unsigned DEF_CN_DEGREE       = 6;
   localparam int unsigned DEF_QUAN_SIZE       = 4;
   localparam int unsigned DEF_LUT_PORT_SIZE   = 3;
   localparam int unsigned DEF_BANK_NUM        = 2;
   localparam int unsigned DEF_PAGE_NUM        = 32;
   localparam int unsigned DEF_MULTI_FRAME_NUM = 2;
   localparam int unsigned DEF_RAM_READERS     = 4;

   localparam int unsigned EDGE_NUM    = DEF_CNU_NUM * DEF_CN_DEGREE;
   localparam int unsigned RAM_NUM     = (EDGE_NUM + DEF_RAM_READERS - 1) / DEF_RAM_READERS;
   localparam int unsigned MAG_W       = DEF_QUAN_SIZE - 1;
   localparam int unsigned PAGE_ADDR_W = 2 * MAG_W - 1;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StDone
   } load_state_e;

   typedef struct packed {
      logic                   sign;
      logic [PAGE_ADDR_W-1:0] page;
      logic                   bank;
   } route_t;

   // Fold both operands onto the positive half so one table serves both signs.
   function automatic route_t route_edge(input logic [DEF_QUAN_SIZE-1:0] t,
                                         input logic [DEF_QUAN_SIZE-1:0] m);
      logic [MAG_W-1:0] mag_t;
      logic [MAG_W-1:0] mag_m;
      route_t           r;
      mag_t  = t[MAG_W] ? t[MAG_W-1:0] : ~t[MAG_W-1:0];
      mag_m  = m[MAG_W] ? m[MAG_W-1:0] : ~m[MAG_W-1:0];
      r.sign = ~(t[MAG_W] ^ m[MAG_W]);
      r.page = {mag_t, mag_m[MAG_W-1:1]};
      r.bank = mag_m[0];
      return r;
   endfunction

endpackage

// File: rtl/sym_lut_ram_nport.sv
// One symmetric IB LUT RAM copy: one write port, Readers registered read ports that apply
// the sign mirroring, shared frame select. Table contents are not reset.
module sym_lut_ram_nport #(
   parameter int unsigned Readers = 4,
   parameter int unsigned PageW   = 5,
   parameter int unsigned DataW   = 3,
   parameter int unsigned FrameW  = 1
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        wr_en_i,
   input  logic [FrameW-1:0]           wr_frame_i,
   input  logic [PageW-1:0]            wr_page_i,
   input  logic [2*DataW-1:0]          wr_data_i,
   input  logic [FrameW-1:0]           rd_frame_i,
   input  logic [Readers*PageW-1:0]    rd_page_i,
   input  logic [Readers-1:0]          rd_bank_i,
   input  logic [Readers-1:0]          rd_sign_i,
   output logic [Readers*(DataW+1)-1:0] rd_c2v_o
);

   localparam int unsigned QW    = DataW + 1;
   localparam int unsigned Depth = 2 ** (FrameW + PageW);

   // Word layout: upper half bank0, lower half bank1.
   logic [2*DataW-1:0]      mem_q [Depth];
   logic [Readers*QW-1:0]   rd_c2v_d;
   logic [Readers*QW-1:0]   rd_c2v_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[{wr_frame_i, wr_page_i}] <= wr_data_i;
      end
   end

   for (genvar p = 0; p < Readers; p++) begin : g_port
      logic [2*DataW-1:0] word;
      logic [DataW-1:0]   lut;
      assign word = mem_q[{rd_frame_i, rd_page_i[p*PageW +: PageW]}];
      assign lut  = rd_bank_i[p] ? word[DataW-1:0] : word[2*DataW-1:DataW];
      assign rd_c2v_d[p*QW +: QW] = rd_sign_i[p] ? {1'b1, lut} : {1'b0, ~lut};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_c2v_q <= '0;
      end else begin
         rd_c2v_q <= rd_c2v_d;
      end
   end

   assign rd_c2v_o = rd_c2v_q;

endmodule

// File: rtl/cnu_lut_stage_pipe.sv
// Final CNU stage: route registers, replicated symmetric LUT RAM reads and a table loader.
// Optional V2C_C2V_PROBE_EN adds v2c_probe, m_in delayed to align with c2v_out.
module cnu_lut_stage_pipe
   import cnu_lut_stage_pipe_pkg::*;
#(
   parameter int unsigned CNU_NUM         = DEF_CNU_NUM,
   parameter int unsigned CN_DEGREE       = DEF_CN_DEGREE,
   parameter int unsigned QUAN_SIZE       = DEF_QUAN_SIZE,
   parameter int unsigned LUT_PORT_SIZE   = DEF_LUT_PORT_SIZE,
   parameter int unsigned BANK_NUM        = DEF_BANK_NUM,
   parameter int unsigned PAGE_NUM        = DEF_PAGE_NUM,
   parameter int unsigned MULTI_FRAME_NUM = DEF_MULTI_FRAME_NUM,
   parameter int unsigned RAM_READERS     = DEF_RAM_READERS
) (
   input  logic                                    read_clk,
   input  logic                                    rst,
   input  logic                                    in_valid,
   input  logic                                    read_addr_offset,
   input  logic [CNU_NUM*CN_DEGREE*QUAN_SIZE-1:0]  t_in,
   input  logic [CNU_NUM*CN_DEGREE*QUAN_SIZE-1:0]  m_in,
   output logic [CNU_NUM*CN_DEGREE*QUAN_SIZE-1:0]  c2v_out,
   output logic                                    out_valid,
   output logic                                    lut_miss,
   output logic                                    read_addr_offset_out,
   input  logic                                    load_start,
   input  logic                                    load_frame,
   input  logic                                    wr_valid,
   output logic                                    wr_ready,
   input  logic [LUT_PORT_SIZE*BANK_NUM-1:0]       wr_data,
   output logic                                    load_done,
   output logic [MULTI_FRAME_NUM-1:0]              frame_valid
`ifdef V2C_C2V_PROBE_EN
   ,
   output logic [CNU_NUM*CN_DEGREE*QUAN_SIZE-1:0]  v2c_probe
`endif
);

   localparam int unsigned EdgeNum = CNU_NUM * CN_DEGREE;
   localparam int unsigned RamNum  = (EdgeNum + RAM_READERS - 1) / RAM_READERS;
   localparam int unsigned PadNum  = RamNum * RAM_READERS;
   localparam int unsigned PageW   = $clog2(PAGE_NUM);
   localparam int unsigned QW      = QUAN_SIZE;

   // Stage 1: routed operands.
   logic                  s1_valid_q, s1_valid_d;
   logic                  s1_offset_q, s1_offset_d;
   logic [PadNum-1:0]     s1_sign_q, s1_sign_d;
   logic [PadNum-1:0]     s1_bank_q, s1_bank_d;
   logic [PadNum*PageW-1:0] s1_page_q, s1_page_d;
   route_t                route_e;

   // Stage 2: sideband aligned with the registered RAM reads.
   logic                  out_valid_q, out_valid_d;
   logic                  lut_miss_q, lut_miss_d;
   logic                  offset_out_q, offset_out_d;
   logic [PadNum*QW-1:0]  c2v_pad;

   // Loader.
   load_state_e           state_q, state_d;
   logic [PageW-1:0]      cnt_q, cnt_d;
   logic                  load_frame_q, load_frame_d;
   logic [MULTI_FRAME_NUM-1:0] frame_valid_q, frame_valid_d;
   logic                  lut_we;

   always_comb begin
      route_e     = '0;
      s1_sign_d   = '0;
      s1_bank_d   = '0;
      s1_page_d   = '0;
      s1_valid_d  = in_valid;
      s1_offset_d = read_addr_offset;
      for (int e = 0; e < EdgeNum; e++) begin
         route_e = route_edge(t_in[e*QW +: QW], m_in[e*QW +: QW]);
         s1_sign_d[e]                = route_e.sign;
         s1_bank_d[e]                = route_e.bank;
         s1_page_d[e*PageW +: PageW] = route_e.page;
      end
   end

   always_comb begin
      out_valid_d  = s1_valid_q;
      lut_miss_d   = ~frame_valid_q[s1_offset_q];
      offset_out_d = s1_offset_q;
   end

   always_ff @(posedge read_clk or posedge rst) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_offset_q  <= 1'b0;
         s1_sign_q    <= '0;
         s1_bank_q    <= '0;
         s1_page_q    <= '0;
         out_valid_q  <= 1'b0;
         lut_miss_q   <= 1'b0;
         offset_out_q <= 1'b0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_offset_q  <= s1_offset_d;
         s1_sign_q    <= s1_sign_d;
         s1_bank_q    <= s1_bank_d;
         s1_page_q    <= s1_page_d;
         out_valid_q  <= out_valid_d;
         lut_miss_q   <= lut_miss_d;
         offset_out_q <= offset_out_d;
      end
   end

   for (genvar g = 0; g < RamNum; g++) begin : g_ram
      sym_lut_ram_nport #(
         .Readers (RAM_READERS),
         .PageW   (PageW),
         .DataW   (LUT_PORT_SIZE),
         .FrameW  (1)
      ) u_ram (
         .clk_i      (read_clk),
         .rst_i      (rst),
         .wr_en_i    (lut_we),
         .wr_frame_i (load_frame_q),
         .wr_page_i  (cnt_q),
         .wr_data_i  (wr_data),
         .rd_frame_i (s1_offset_q),
         .rd_page_i  (s1_page_q[g*RAM_READERS*PageW +: RAM_READERS*PageW]),
         .rd_bank_i  (s1_bank_q[g*RAM_READERS +: RAM_READERS]),
         .rd_sign_i  (s1_sign_q[g*RAM_READERS +: RAM_READERS]),
         .rd_c2v_o   (c2v_pad[g*RAM_READERS*QW +: RAM_READERS*QW])
      );
   end

   assign c2v_out              = c2v_pad[EdgeNum*QW-1:0];
   assign out_valid            = out_valid_q;
   assign lut_miss             = lut_miss_q;
   assign read_addr_offset_out = offset_out_q;
   assign frame_valid          = frame_valid_q;

   always_ff @(posedge read_clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         load_frame_q  <= 1'b0;
         frame_valid_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         load_frame_q  <= load_frame_d;
         frame_valid_q <= frame_valid_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      load_frame_d  = load_frame_q;
      frame_valid_d = frame_valid_q;
      unique case (state_q)
         StIdle: begin
            if (load_start) begin
               state_d                   = StLoad;
               load_frame_d              = load_frame;
               frame_valid_d[load_frame] = 1'b0;
               cnt_d                     = '0;
            end
         end
         StLoad: begin
            if (wr_valid) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == PageW'(PAGE_NUM - 1)) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            frame_valid_d[load_frame_q] = 1'b1;
            state_d                     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      wr_ready  = (state_q == StLoad);
      load_done = (state_q == StDone);
      lut_we    = (state_q == StLoad) & wr_valid;
   end

`ifdef V2C_C2V_PROBE_EN
   logic [EdgeNum*QW-1:0] probe_s1_q, probe_s1_d;
   logic [EdgeNum*QW-1:0] probe_s2_q, probe_s2_d;

   always_comb begin
      probe_s1_d = m_in;
      probe_s2_d = probe_s1_q;
   end

   always_ff @(posedge read_clk or posedge rst) begin
      if (rst) begin
         probe_s1_q <= '0;
         probe_s2_q <= '0;
      end else begin
         probe_s1_q <= probe_s1_d;
         probe_s2_q <= probe_s2_d;
      end
   end

   assign v2c_probe = probe_s2_q;
`endif

endmodule

// File: tb/tb_cnu_lut_stage_pipe.sv
// Scoreboard bench for cnu_lut_stage_pipe: a bench-side table model predicts every C2V set.
module tb_cnu_lut_stage_pipe;

   localparam int EN = 12;
   localparam int QW = 4;
   localparam int EQ = EN * QW;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          read_addr_offset;
   logic [EQ-1:0] t_in;
   logic [EQ-1:0] m_in;
   logic [EQ-1:0] c2v_out;
   logic          out_valid;
   logic          lut_miss;
   logic          read_addr_offset_out;
   logic          load_start;
   logic          load_frame;
   logic          wr_valid;
   logic          wr_ready;
   logic [5:0]    wr_data;
   logic          load_done;
   logic [1:0]    frame_valid;
`ifdef V2C_C2V_PROBE_EN
   logic [EQ-1:0] v2c_probe;
`endif

   cnu_lut_stage_pipe dut (
      .read_clk             (clk),
      .rst                  (rst),
      .in_valid             (in_valid),
      .read_addr_offset     (read_addr_offset),
      .t_in                 (t_in),
      .m_in                 (m_in),
      .c2v_out              (c2v_out),
      .out_valid            (out_valid),
      .lut_miss             (lut_miss),
      .read_addr_offset_out (read_addr_offset_out),
      .load_start           (load_start),
      .load_frame           (load_frame),
      .wr_valid             (wr_valid),
      .wr_ready             (wr_ready),
      .wr_data              (wr_data),
      .load_done            (load_done),
`ifdef V2C_C2V_PROBE_EN
      .v2c_probe            (v2c_probe),
`endif
      .frame_valid          (frame_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Bench-side table model.
   logic [5:0] model_mem [2][32];
   logic [1:0] model_fv   = 2'b00;
   logic [1:0] model_ever = 2'b00;

   typedef struct {
      logic [EQ-1:0] c2v;
      logic [EQ-1:0] m;
      logic          miss;
      logic          off;
      logic          dchk;
      int            cyc;
   } sb_entry_t;

   sb_entry_t sb[$];
   sb_entry_t mon_e;

   function automatic logic [5:0] pat(input int f, input int p);
      logic [4:0] pp;
      pp = p[4:0];
      if (f == 0) return {pp[2:0], ~pp[2:0]};
      return {pp[2:0] ^ 3'b101, pp[4:2]};
   endfunction

   function automatic logic [EQ-1:0] model_c2v(input logic [EQ-1:0] t, input logic [EQ-1:0] m,
                                               input logic f);
      logic [EQ-1:0] r;
      logic [3:0]    tq, mq;
      logic [2:0]    mt, mm, lut;
      logic [4:0]    page;
      logic [5:0]    word;
      r = '0;
      for (int e = 0; e < EN; e++) begin
         tq   = t[e*QW +: QW];
         mq   = m[e*QW +: QW];
         mt   = tq[3] ? tq[2:0] : ~tq[2:0];
         mm   = mq[3] ? mq[2:0] : ~mq[2:0];
         page = {mt, mm[2:1]};
         word = model_mem[f][page];
         lut  = mm[0] ? word[2:0] : word[5:3];
         r[e*QW +: QW] = (tq[3] == mq[3]) ? {1'b1, lut} : {1'b0, ~lut};
      end
      return r;
   endfunction

   task automatic drive_set(input logic [EQ-1:0] t, input logic [EQ-1:0] m, input logic off);
      sb_entry_t en;
      t_in             = t;
      m_in             = m;
      read_addr_offset = off;
      in_valid         = 1'b1;
      en.c2v  = model_c2v(t, m, off);
      en.m    = m;
      en.miss = ~model_fv[off];
      en.off  = off;
      en.dchk = model_ever[off];
      en.cyc  = cyc + 2;
      sb.push_back(en);
      @(negedge clk);
   endtask

   task automatic rand_vecs(output logic [EQ-1:0] t, output logic [EQ-1:0] m);
      logic [63:0] r64;
      r64 = {$urandom(), $urandom()};
      t   = r64[EQ-1:0];
      r64 = {$urandom(), $urandom()};
      m   = r64[EQ-1:0];
   endtask

   task automatic stream_reads(input int n, input logic off);
      logic [EQ-1:0] t, m;
      for (int i = 0; i < n; i++) begin
         rand_vecs(t, m);
         drive_set(t, m, off);
      end
      in_valid = 1'b0;
   endtask

   task automatic do_load(input int f, input bit gaps);
      int done_cnt;
      @(negedge clk);
      load_start = 1'b1;
      load_frame = f[0];
      @(negedge clk);
      load_start   = 1'b0;
      model_fv[f]  = 1'b0;
      check("wr_ready_in_load", wr_ready, 1);
      for (int p = 0; p < 32; p++) begin
         if (gaps && (p % 5 == 2)) begin
            wr_valid = 1'b0;
            wr_data  = 6'h3f;
            @(negedge clk);
         end
         wr_valid = 1'b1;
         wr_data  = pat(f, p);
         @(negedge clk);
         model_mem[f][p] = pat(f, p);
      end
      wr_valid = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         if (load_done) done_cnt++;
         @(negedge clk);
      end
      check("load_done_pulses", done_cnt, 1);
      model_fv[f]   = 1'b1;
      model_ever[f] = 1'b1;
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_out", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            check("latency", cyc, mon_e.cyc);
            if (mon_e.dchk) check("c2v", c2v_out, mon_e.c2v);
            check("lut_miss", lut_miss, mon_e.miss);
            check("offset_out", read_addr_offset_out, mon_e.off);
`ifdef V2C_C2V_PROBE_EN
            check("v2c_probe", v2c_probe, mon_e.m);
`endif
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [EQ-1:0] tv, mv;
      rst              = 1'b1;
      in_valid         = 1'b0;
      read_addr_offset = 1'b0;
      t_in             = '0;
      m_in             = '0;
      load_start       = 1'b0;
      load_frame       = 1'b0;
      wr_valid         = 1'b0;
      wr_data          = '0;
      repeat (3) @(negedge clk);
      check("rst_c2v", c2v_out, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_lut_miss", lut_miss, 0);
      check("rst_offset_out", read_addr_offset_out, 0);
      check("rst_wr_ready", wr_ready, 0);
      check("rst_load_done", load_done, 0);
      check("rst_frame_valid", frame_valid, 0);
      rst = 1'b0;
      @(negedge clk);

      do_load(0, 1'b0);
      check("fv_after_load0", frame_valid, 2'b01);

      // Positive-sign case: page 14, bank1, lut 001.
      rand_vecs(tv, mv);
      tv[3:0] = 4'b1011;
      mv[3:0] = 4'b1101;
      drive_set(tv, mv, 1'b0);
      in_valid = 1'b0;
      @(negedge clk);
      check("dir_pos_c2v", c2v_out[3:0], 4'b1001);
      check("dir_pos_valid", out_valid, 1);
      check("dir_pos_miss", lut_miss, 0);

      // Negative-sign mirror of the same entry.
      tv[3:0] = 4'b0100;
      drive_set(tv, mv, 1'b0);
      in_valid = 1'b0;
      @(negedge clk);
      check("dir_neg_c2v", c2v_out[3:0], 4'b0110);
      @(negedge clk);
      check("idle_out_valid", out_valid, 0);

      // Back-to-back sets, frame1 not yet loaded.
      rand_vecs(tv, mv);
      drive_set(tv, mv, 1'b0);
      rand_vecs(tv, mv);
      drive_set(tv, mv, 1'b1);
      rand_vecs(tv, mv);
      drive_set(tv, mv, 1'b0);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);

      // Load frame1 with beat gaps while frame0 reads stream.
      fork
         do_load(1, 1'b1);
         stream_reads(60, 1'b0);
      join
      repeat (3) @(negedge clk);
      check("fv_after_load1", frame_valid, 2'b11);
      stream_reads(8, 1'b1);
      stream_reads(4, 1'b0);
      repeat (4) @(negedge clk);

      // Abort a reload of frame1 after 10 beats.
      load_start = 1'b1;
      load_frame = 1'b1;
      @(negedge clk);
      load_start  = 1'b0;
      model_fv[1] = 1'b0;
      for (int p = 0; p < 10; p++) begin
         wr_valid = 1'b1;
         wr_data  = pat(1, p);
         @(negedge clk);
         model_mem[1][p] = pat(1, p);
      end
      wr_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      check("abort_wr_ready", wr_ready, 0);
      check("abort_frame_valid", frame_valid, 2'b00);
      check("abort_load_done", load_done, 0);
      rst      = 1'b0;
      model_fv = 2'b00;
      @(negedge clk);
      check("abort_idle_wr_ready", wr_ready, 0);

      do_load(0, 1'b0);
      check("fv_after_reload0", frame_valid, 2'b01);
      stream_reads(6, 1'b0);
      stream_reads(3, 1'b1);
      repeat (4) @(negedge clk);

`ifdef V2C_C2V_PROBE_EN
      rand_vecs(tv, mv);
      mv[47:44] = 4'hA;
      drive_set(tv, mv, 1'b0);
      in_valid = 1'b0;
      @(negedge clk);
      check("probe_edge11", v2c_probe[47:44], 4'hA);
      check("probe_valid", out_valid, 1);
      repeat (3) @(negedge clk);
`endif

      for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
      check("sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
